// File: rtl/multi_gate_alarm.sv
// multi_gate_alarm
//   N-channel gate alarm controller. Each channel watches one gate sensor and
//   raises an alarm if the gate opens without an access request inside
//   TIMEOUT cycles. It also raises an alarm if the gate stays open more than
//   HOLD_MAX cycles after an accepted request (tailgating). A saturating
//   counter records how many times any channel has entered ALARM.
//
// Ports
//   clk          sole clock, all state updates on the rising edge
//   reset        synchronous, active-high, dominates all other inputs
//   gate         per-channel gate-open sensor (level, 1 = open)
//   request      per-channel access request, only looked at while waiting
//   clear        per-channel alarm acknowledge
//   alarm        per-channel alarm, decoded straight from the state register
//   any_alarm    OR of alarm
//   alarm_count  saturating count of ALARM entries since reset
//
// Per-channel states
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | gate closed, nothing pending
//   S_WAIT  | gate opened, waiting for an access request (TIMEOUT timer)
//   S_OPEN  | request accepted, gate allowed open (HOLD_MAX timer)
//   S_ALARM | alarm raised, held until clear with the gate closed

module multi_gate_alarm #(
    parameter int N_CH     = 4,
    parameter int TIMEOUT  = 8,
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  gate,
    input  logic [N_CH-1:0]  request,
    input  logic [N_CH-1:0]  clear,
    output logic [N_CH-1:0]  alarm,
    output logic             any_alarm,
    output logic [CNT_W-1:0] alarm_count
);

    localparam int T_MAX = (TIMEOUT > HOLD_MAX) ? TIMEOUT : HOLD_MAX;
    localparam int TW    = $clog2(T_MAX + 1);
    // Wide enough to hold a saturated count plus every channel entering at once.
    localparam int SUM_W = CNT_W + $clog2(N_CH + 1);

    localparam logic [TW-1:0]    T_WAIT_LOAD = TW'(TIMEOUT);
    localparam logic [TW-1:0]    T_OPEN_LOAD = TW'(HOLD_MAX);
    localparam logic [TW-1:0]    T_ONE       = TW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_OPEN  = 2'd2,
        S_ALARM = 2'd3
    } state_t;

    state_t            state_q [N_CH];
    state_t            state_d [N_CH];
    logic [TW-1:0]     timer_q [N_CH];
    logic [TW-1:0]     timer_d [N_CH];
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [SUM_W-1:0]  n_enter;
    logic [SUM_W-1:0]  count_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= S_IDLE;
                timer_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
            count_q <= count_d;
        end
    end

    always_comb begin
        n_enter   = '0;
        count_sum = '0;
        count_d   = count_q;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (gate[i]) begin
                        state_d[i] = S_WAIT;
                        timer_d[i] = T_WAIT_LOAD;
                    end
                end
                S_WAIT: begin
                    // A request on the last allowed edge still beats the timeout,
                    // and also beats a gate that closes on the same edge.
                    if (request[i]) begin
                        state_d[i] = S_OPEN;
                        timer_d[i] = T_OPEN_LOAD;
                    end else if (!gate[i]) begin
                        state_d[i] = S_IDLE;
                        timer_d[i] = '0;
                    end else if (timer_q[i] == T_ONE) begin
                        state_d[i] = S_ALARM;
                        timer_d[i] = '0;
                    end else begin
                        timer_d[i] = timer_q[i] - T_ONE;
                    end
                end
                S_OPEN: begin
                    if (!gate[i]) begin
                        state_d[i] = S_IDLE;
                        timer_d[i] = '0;
                    end else if (timer_q[i] == T_ONE) begin
                        state_d[i] = S_ALARM;
                        timer_d[i] = '0;
                    end else begin
                        timer_d[i] = timer_q[i] - T_ONE;
                    end
                end
                S_ALARM: begin
                    if (clear[i] && !gate[i]) begin
                        state_d[i] = S_IDLE;
                    end
                end
                default: begin
                    state_d[i] = S_IDLE;
                    timer_d[i] = '0;
                end
            endcase
            if (state_d[i] == S_ALARM && state_q[i] != S_ALARM) begin
                n_enter = n_enter + SUM_W'(1);
            end
        end
        count_sum = SUM_W'(count_q) + n_enter;
        if (count_sum > SUM_W'(CNT_MAX)) begin
            count_d = CNT_MAX;
        end else begin
            count_d = count_sum[CNT_W-1:0];
        end
    end

    always_comb begin
        alarm = '0;
        for (int i = 0; i < N_CH; i++) begin
            alarm[i] = (state_q[i] == S_ALARM);
        end
    end

    assign any_alarm   = |alarm;
    assign alarm_count = count_q;

endmodule

// File: tb/tb_multi_gate_alarm.sv
module tb_multi_gate_alarm;

    localparam int N_CH     = 4;
    localparam int TIMEOUT  = 8;
    localparam int HOLD_MAX = 16;

    localparam int M_IDLE  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_OPEN  = 2;
    localparam int M_ALARM = 3;

    logic            clk;
    logic            reset;
    logic [N_CH-1:0] gate;
    logic [N_CH-1:0] request;
    logic [N_CH-1:0] clear;
    logic [N_CH-1:0] alarm;
    logic            any_alarm;
    logic [7:0]      alarm_count;
    logic [N_CH-1:0] alarm_s;
    logic            any_alarm_s;
    logic [1:0]      alarm_count_s;

    int n_vec;
    int n_err;

    // Reference model: each channel is a mode plus an absolute deadline edge.
    int m_mode     [N_CH];
    int m_deadline [N_CH];
    int m_total;
    int edge_no;

    multi_gate_alarm #(.N_CH(N_CH), .TIMEOUT(TIMEOUT), .HOLD_MAX(HOLD_MAX), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .gate(gate), .request(request), .clear(clear),
        .alarm(alarm), .any_alarm(any_alarm), .alarm_count(alarm_count)
    );

    multi_gate_alarm #(.N_CH(N_CH), .TIMEOUT(TIMEOUT), .HOLD_MAX(HOLD_MAX), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .gate(gate), .request(request), .clear(clear),
        .alarm(alarm_s), .any_alarm(any_alarm_s), .alarm_count(alarm_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N_CH-1:0] exp_alarm();
        logic [N_CH-1:0] v;
        v = '0;
        for (int i = 0; i < N_CH; i++) v[i] = (m_mode[i] == M_ALARM);
        return v;
    endfunction

    function automatic logic [7:0] exp_cnt8();
        return (m_total > 255) ? 8'd255 : 8'(m_total);
    endfunction

    function automatic logic [1:0] exp_cnt2();
        return (m_total > 3) ? 2'd3 : 2'(m_total);
    endfunction

    task automatic model_edge(input logic [N_CH-1:0] g, input logic [N_CH-1:0] r,
                              input logic [N_CH-1:0] c, input logic rst);
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                m_mode[i] = M_IDLE;
                m_deadline[i] = 0;
            end
            m_total = 0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (m_mode[i] == M_IDLE) begin
                    if (g[i]) begin
                        m_mode[i] = M_WAIT;
                        m_deadline[i] = edge_no + TIMEOUT;
                    end
                end else if (m_mode[i] == M_WAIT) begin
                    if (r[i]) begin
                        m_mode[i] = M_OPEN;
                        m_deadline[i] = edge_no + HOLD_MAX;
                    end else if (!g[i]) begin
                        m_mode[i] = M_IDLE;
                    end else if (edge_no == m_deadline[i]) begin
                        m_mode[i] = M_ALARM;
                        m_total++;
                    end
                end else if (m_mode[i] == M_OPEN) begin
                    if (!g[i]) begin
                        m_mode[i] = M_IDLE;
                    end else if (edge_no == m_deadline[i]) begin
                        m_mode[i] = M_ALARM;
                        m_total++;
                    end
                end else begin
                    if (c[i] && !g[i]) m_mode[i] = M_IDLE;
                end
            end
        end
        edge_no++;
    endtask

    // Drive one edge's inputs, advance the model, and settle just after the edge.
    task automatic apply(input logic [N_CH-1:0] g, input logic [N_CH-1:0] r,
                         input logic [N_CH-1:0] c, input logic rst);
        @(negedge clk);
        gate = g; request = r; clear = c; reset = rst;
        @(posedge clk);
        model_edge(g, r, c, rst);
        #1;
    endtask

    task automatic test_reset();
        apply(4'($urandom), 4'($urandom), 4'($urandom), 1'b1);
        n_vec++;
        if (alarm !== 4'b0 || any_alarm !== 1'b0 || alarm_count !== 8'd0 || alarm_count_s !== 2'd0) begin
            n_err++;
            $display("FAIL reset: alarm=%b any=%b cnt=%0d cnt2=%0d required all zero",
                     alarm, any_alarm, alarm_count, alarm_count_s);
        end
    endtask

    task automatic test_request_window();
        apply('0, '0, '0, 1'b1);
        for (int e = 0; e <= 8; e++) begin
            apply({3'b0, (e <= 5)}, {3'b0, (e == 3)}, '0, 1'b0);
            n_vec++;
            if (alarm !== exp_alarm() || alarm[0] !== 1'b0 || alarm_count !== 8'd0) begin
                n_err++;
                $display("FAIL req_window e=%0d: alarm=%b cnt=%0d required alarm=%b cnt=0",
                         e, alarm, alarm_count, exp_alarm());
            end
        end
        // Channel 0 must be idle again: a fresh unanswered opening times out exactly TIMEOUT edges later.
        for (int e = 0; e <= TIMEOUT; e++) begin
            apply(4'b0001, '0, '0, 1'b0);
            n_vec++;
            if (alarm[0] !== (e == TIMEOUT) || alarm !== exp_alarm()) begin
                n_err++;
                $display("FAIL req_window_idle e=%0d: alarm=%b required alarm0=%0d", e, alarm, (e == TIMEOUT));
            end
        end
    endtask

    task automatic test_timeout();
        apply('0, '0, '0, 1'b1);
        for (int e = 0; e <= 8; e++) begin
            apply(4'b0010, '0, '0, 1'b0);
            n_vec++;
            if (alarm[1] !== (e == 8) || any_alarm !== (e == 8) || alarm !== exp_alarm()) begin
                n_err++;
                $display("FAIL timeout e=%0d: alarm=%b any=%b required alarm1=%0d", e, alarm, any_alarm, (e == 8));
            end
        end
        n_vec++;
        if (alarm_count !== 8'd1 || alarm_count_s !== 2'd1) begin
            n_err++;
            $display("FAIL timeout_count: cnt=%0d cnt2=%0d required 1", alarm_count, alarm_count_s);
        end
        apply('0, '0, 4'b0010, 1'b0);
        n_vec++;
        if (alarm !== 4'b0 || any_alarm !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_clear: alarm=%b any=%b required 0", alarm, any_alarm);
        end
    endtask

    task automatic test_boundary();
        for (int req_edge = 8; req_edge <= 9; req_edge++) begin
            apply('0, '0, '0, 1'b1);
            for (int e = 0; e <= req_edge; e++) begin
                apply(4'b0100, {1'b0, (e == req_edge), 2'b0}, '0, 1'b0);
                n_vec++;
                if (alarm[2] !== (req_edge == 9 && e >= 8) || alarm !== exp_alarm()) begin
                    n_err++;
                    $display("FAIL boundary req=%0d e=%0d: alarm=%b required alarm2=%0d",
                             req_edge, e, alarm, (req_edge == 9 && e >= 8));
                end
            end
            apply('0, '0, '0, 1'b0);
            n_vec++;
            if (alarm[2] !== (req_edge == 9) || alarm_count !== 8'(req_edge - 8)) begin
                n_err++;
                $display("FAIL boundary_end req=%0d: alarm=%b cnt=%0d required alarm2=%0d cnt=%0d",
                         req_edge, alarm, alarm_count, (req_edge == 9), req_edge - 8);
            end
        end
    endtask

    task automatic test_hold();
        for (int drop = 0; drop <= 1; drop++) begin
            apply('0, '0, '0, 1'b1);
            for (int e = 0; e <= 18; e++) begin
                apply({3'b0, !(e == 18 && drop == 1)}, {3'b0, (e == 2)}, '0, 1'b0);
                n_vec++;
                if (alarm[0] !== (e == 18 && drop == 0) || alarm !== exp_alarm() || alarm_count !== exp_cnt8()) begin
                    n_err++;
                    $display("FAIL hold drop=%0d e=%0d: alarm=%b cnt=%0d required alarm0=%0d",
                             drop, e, alarm, alarm_count, (e == 18 && drop == 0));
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        apply('0, '0, '0, 1'b1);
        for (int round = 1; round <= 2; round++) begin
            for (int e = 0; e <= 8; e++) apply(4'b1011, '0, '0, 1'b0);
            n_vec++;
            if (alarm !== 4'b1011 || alarm_count !== 8'(3 * round) || alarm_count_s !== 2'd3) begin
                n_err++;
                $display("FAIL simultaneous round=%0d: alarm=%b cnt=%0d cnt2=%0d required alarm=1011 cnt=%0d cnt2=3",
                         round, alarm, alarm_count, alarm_count_s, 3 * round);
            end
            apply('0, '0, 4'b1111, 1'b0);
            n_vec++;
            if (alarm !== 4'b0 || alarm_count_s !== 2'd3) begin
                n_err++;
                $display("FAIL simultaneous_clear round=%0d: alarm=%b cnt2=%0d required 0000 / 3",
                         round, alarm, alarm_count_s);
            end
        end
    endtask

    task automatic test_clear();
        apply('0, '0, '0, 1'b1);
        for (int e = 0; e <= 8; e++) apply(4'b1000, '0, '0, 1'b0);
        apply(4'b1000, '0, 4'b1000, 1'b0);
        n_vec++;
        if (alarm !== 4'b1000) begin
            n_err++;
            $display("FAIL clear_gate_high: alarm=%b required 1000", alarm);
        end
        apply('0, '0, 4'b1000, 1'b0);
        n_vec++;
        if (alarm !== 4'b0000 || any_alarm !== 1'b0) begin
            n_err++;
            $display("FAIL clear_gate_low: alarm=%b any=%b required 0000/0", alarm, any_alarm);
        end
    endtask

    task automatic test_reset_mid();
        apply('0, '0, '0, 1'b1);
        for (int e = 0; e <= 5; e++) apply(4'b0001, '0, '0, 1'b0);
        apply(4'b0001, 4'b0001, 4'b0001, 1'b1);
        n_vec++;
        if (alarm !== 4'b0 || any_alarm !== 1'b0 || alarm_count !== 8'd0) begin
            n_err++;
            $display("FAIL reset_mid: alarm=%b any=%b cnt=%0d required zero", alarm, any_alarm, alarm_count);
        end
        for (int e = 0; e < 12; e++) begin
            apply('0, '0, '0, 1'b0);
            n_vec++;
            if (alarm !== 4'b0 || alarm_count !== 8'd0) begin
                n_err++;
                $display("FAIL reset_mid_after e=%0d: alarm=%b cnt=%0d required zero", e, alarm, alarm_count);
            end
        end
    endtask

    task automatic test_random();
        logic [N_CH-1:0] g;
        logic [N_CH-1:0] r;
        logic [N_CH-1:0] c;
        g = '0;
        apply('0, '0, '0, 1'b1);
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < N_CH; i++) begin
                if ($urandom_range(0, 5) == 0) g[i] = ~g[i];
                r[i] = ($urandom_range(0, 11) == 0);
                c[i] = ($urandom_range(0, 3) == 0);
            end
            apply(g, r, c, ($urandom_range(0, 299) == 0));
            n_vec++;
            if (alarm !== exp_alarm() || any_alarm !== (|exp_alarm()) ||
                alarm_count !== exp_cnt8() || alarm_count_s !== exp_cnt2()) begin
                n_err++;
                $display("FAIL random k=%0d: alarm=%b any=%b cnt=%0d cnt2=%0d required alarm=%b cnt=%0d cnt2=%0d",
                         k, alarm, any_alarm, alarm_count, alarm_count_s, exp_alarm(), exp_cnt8(), exp_cnt2());
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        edge_no = 0;
        m_total = 0;
        for (int i = 0; i < N_CH; i++) begin
            m_mode[i] = M_IDLE;
            m_deadline[i] = 0;
        end
        gate = '0; request = '0; clear = '0; reset = 1'b1;
        test_reset();
        test_request_window();
        test_timeout();
        test_boundary();
        test_hold();
        test_simultaneous();
        test_clear();
        test_reset_mid();
        test_random();
        test_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
